// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV64 M DIV/DIVU/REM/REMU.
// Define DIV_WORD_OP_EN to add the `word` port and the 32-bit W-variant datapath.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
`ifdef DIV_WORD_OP_EN
    input  logic                  word,
`endif
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MIN_FULL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q;
    logic             busy_q;
    logic             valid_q;
    logic [W-1:0]     result_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quot_q;
    logic [W-1:0]     div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             rem_sel_q;
`ifdef DIV_WORD_OP_EN
    logic             word_q;
`endif

    // Operand decode: extension, magnitudes, signs and the special cases.
    logic         is_signed;
    logic         a_neg;
    logic         b_neg;
    logic         b_zero;
    logic         ovf;
    logic         special;
    logic [W-1:0] a_ext;
    logic [W-1:0] b_ext;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] ovf_pat;
    logic [W-1:0] dividend;
    logic [W-1:0] spec_raw;
    logic [W-1:0] spec_res;

    assign is_signed = ~op[0];

`ifdef DIV_WORD_OP_EN
    localparam int unsigned HALF_W = 32;
    localparam logic [W-1:0] MIN_WORD = {{(W-HALF_W+1){1'b1}}, {(HALF_W-1){1'b0}}};

    function automatic logic [W-1:0] sext_word(input logic [HALF_W-1:0] v);
        return {{(W-HALF_W){v[HALF_W-1]}}, v};
    endfunction

    always_comb begin
        a_ext = a;
        b_ext = b;
        if (word) begin
            a_ext = {{(W-HALF_W){is_signed & a[HALF_W-1]}}, a[HALF_W-1:0]};
            b_ext = {{(W-HALF_W){is_signed & b[HALF_W-1]}}, b[HALF_W-1:0]};
        end
    end

    assign ovf_pat = word ? MIN_WORD : MIN_FULL;
`else
    assign a_ext   = a;
    assign b_ext   = b;
    assign ovf_pat = MIN_FULL;
`endif

    assign a_neg   = is_signed & a_ext[W-1];
    assign b_neg   = is_signed & b_ext[W-1];
    assign a_mag   = a_neg ? W'(-a_ext) : a_ext;
    assign b_mag   = b_neg ? W'(-b_ext) : b_ext;
    assign b_zero  = (b_ext == '0);
    assign ovf     = is_signed & (a_ext == ovf_pat) & (b_ext == ALL_ONES);
    assign special = b_zero | ovf;

    // Divide-by-zero: q=-1, r=a. Signed overflow: q=a, r=0.
    always_comb begin
        spec_raw = '0;
        if (b_zero) begin
            spec_raw = op[1] ? a_ext : ALL_ONES;
        end else begin
            spec_raw = op[1] ? '0 : a_ext;
        end
    end

`ifdef DIV_WORD_OP_EN
    assign spec_res = word ? sext_word(spec_raw[HALF_W-1:0]) : spec_raw;
    // Word dividend sits in the top half so that 32 shifts consume it exactly.
    assign dividend = word ? (a_mag << HALF_W) : a_mag;
`else
    assign spec_res = spec_raw;
    assign dividend = a_mag;
`endif

    // One restoring step: shift {rem, quot} left, trial-subtract the divisor.
    logic [W:0]   rem_sh;
    logic [W:0]   diff;
    logic [W-1:0] rem_d;
    logic [W-1:0] quot_d;

    assign rem_sh = {rem_q, quot_q[W-1]};
    assign diff   = rem_sh - {1'b0, div_q};
    assign rem_d  = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
    assign quot_d = {quot_q[W-2:0], ~diff[W]};

    // Sign fix-up and quotient/remainder selection.
    logic [W-1:0]     q_fix;
    logic [W-1:0]     r_fix;
    logic [W-1:0]     fix_sel;
    logic [W-1:0]     fix_res;
    logic [CNT_W-1:0] last_cnt;

    assign q_fix   = qneg_q ? W'(-quot_q) : quot_q;
    assign r_fix   = rneg_q ? W'(-rem_q) : rem_q;
    assign fix_sel = rem_sel_q ? r_fix : q_fix;

`ifdef DIV_WORD_OP_EN
    assign fix_res  = word_q ? sext_word(fix_sel[HALF_W-1:0]) : fix_sel;
    assign last_cnt = word_q ? CNT_W'(HALF_W - 1) : CNT_W'(W - 1);
`else
    assign fix_res  = fix_sel;
    assign last_cnt = CNT_W'(W - 1);
`endif

    // Control FSM and datapath registers; flush aborts without touching result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rem_sel_q <= 1'b0;
`ifdef DIV_WORD_OP_EN
            word_q    <= 1'b0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        rem_sel_q <= op[1];
                        qneg_q    <= a_neg ^ b_neg;
                        rneg_q    <= a_neg;
                        div_q     <= b_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
`ifdef DIV_WORD_OP_EN
                        word_q    <= word;
`endif
                        if (special) begin
                            quot_q  <= spec_res;
                            state_q <= S_DONE;
                        end else begin
                            quot_q  <= dividend;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == last_cnt) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quot_q  <= fix_res;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    result_q <= quot_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: table-driven vectors checked through a result scoreboard,
// plus flush, start-while-busy and mid-operation reset sequences.
module tb_div_unit;

    localparam int unsigned W   = 64;
    localparam int          TMO = 200;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          LN  = 66;
    localparam int          LS  = 1;

    typedef struct {
        logic [1:0]  op;
        logic        wd;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] exp;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        valid;
    logic [63:0] result;
`ifdef DIV_WORD_OP_EN
    logic        word;
`endif

    int   n_cmp;
    int   n_fail;
    sb_t  sb_q[$];
    vec_t vecs[$];
    sb_t  mon_e;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
`ifdef DIV_WORD_OP_EN
        .word   (word),
`endif
        .flush  (flush),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, want %h", name, id, act, exp);
        end
    endtask

    // Reference model built on the simulator's own division operators.
    function automatic logic [63:0] ref_div(input logic [1:0] f, input logic [63:0] x,
                                            input logic [63:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        if (y == 64'd0) return f[1] ? x : ONES;
        if (!f[0] && x == MIN64 && y == ONES) return f[1] ? 64'd0 : x;
        case (f)
            2'b00:   return 64'(sx / sy);
            2'b01:   return x / y;
            2'b10:   return 64'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    task automatic add(input logic [1:0] f, input logic wd, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] e, input int lat);
        vec_t v;
        v.op = f; v.wd = wd; v.a = x; v.b = y; v.exp = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue one op, push its expected result, then time the valid pulse.
    task automatic run_op(input vec_t v, input int id, input int poke);
        int  cyc;
        sb_t e;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
`ifdef DIV_WORD_OP_EN
        word = v.wd;
`endif
        e.id = id; e.exp = v.exp;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", id, 64'(busy), 64'd1);
        cyc = 0;
        while (!valid && cyc < TMO) begin
            @(negedge clk);
            cyc++;
            if (poke > 0 && cyc == poke) begin
                start = 1'b1; op = 2'b01; a = 64'd1000; b = 64'd3;
            end else if (poke > 0 && cyc == poke + 1) begin
                start = 1'b0;
            end
        end
        chk("latency", id, 64'(cyc), 64'(v.lat));
        if (valid) begin
            chk("busy_at_valid", id, 64'(busy), 64'd0);
            @(negedge clk);
            chk("valid_one_cycle", id, 64'(valid), 64'd0);
            chk("result_held", id, result, v.exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: result=%h, no result was expected", result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", mon_e.id, result, mon_e.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        v;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  rf;
        logic        seen;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef DIV_WORD_OP_EN
        word = 1'b0;
`endif
        n_cmp = 0; n_fail = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 0, 64'(busy), 64'd0);
        chk("reset_valid", 0, 64'(valid), 64'd0);
        chk("reset_result", 0, result, 64'd0);
        rst_n = 1'b1;

        add(2'b01, 1'b0, 64'd100, 64'd7, 64'd14, LN);
        add(2'b11, 1'b0, 64'd100, 64'd7, 64'd2, LN);
        add(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, LN);
        add(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LN);
        add(2'b00, 1'b0, 64'd5, 64'd0, ONES, LS);
        add(2'b10, 1'b0, 64'd5, 64'd0, 64'd5, LS);
        add(2'b00, 1'b0, MIN64, ONES, MIN64, LS);
        add(2'b10, 1'b0, MIN64, ONES, 64'd0, LS);
        add(2'b01, 1'b0, 64'd5, 64'd0, ONES, LS);
        add(2'b11, 1'b0, 64'd5, 64'd0, 64'd5, LS);
        add(2'b01, 1'b0, ONES, 64'd1, ONES, LN);
        add(2'b00, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, LN);
        add(2'b10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, LN);
        add(2'b01, 1'b0, MIN64, ONES, 64'd0, LN);
        add(2'b11, 1'b0, MIN64, ONES, MIN64, LN);
        add(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, LN);
        add(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
            64'hFFFF_FFFF_FFFF_FFFE, LN);
        add(2'b01, 1'b0, 64'd3, 64'd7, 64'd0, LN);
        add(2'b11, 1'b0, 64'd3, 64'd7, 64'd3, LN);
        add(2'b00, 1'b0, MIN64, 64'd2, 64'hC000_0000_0000_0000, LN);
`ifdef DIV_WORD_OP_EN
        add(2'b00, 1'b1, 64'h0000_0001_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 34);
        add(2'b01, 1'b1, 64'h0000_0001_FFFF_FFF8, 64'd2, 64'h0000_0000_7FFF_FFFC, 34);
        add(2'b10, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0001_0000_0000,
            64'hFFFF_FFFF_8000_0000, LS);
        add(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, LS);
        add(2'b11, 1'b1, 64'd100, 64'd7, 64'd2, 34);
        add(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 34);
`endif
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(63, 0);
            rf = 2'($urandom_range(3, 0));
            add(rf, 1'b0, ra, rb, ref_div(rf, ra, rb),
                (rb == 64'd0 || (!rf[0] && ra == MIN64 && rb == ONES)) ? LS : LN);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], i, 0);
        end

        // A second start while busy must be ignored, operands stay latched.
        v.op = 2'b01; v.wd = 1'b0; v.a = 64'd100; v.b = 64'd7; v.exp = 64'd14; v.lat = LN;
        run_op(v, 100, 5);

        // Flush mid-CALC: busy drops, no valid, result keeps 14.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 64'd1000; b = 64'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_busy_before", 200, 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", 200, 64'(busy), 64'd0);
        chk("flush_valid", 200, 64'(valid), 64'd0);
        chk("flush_result_kept", 200, result, 64'd14);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        chk("flush_no_valid", 200, 64'(seen), 64'd0);

        // Flush wins over start in the same cycle.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 64'd5; b = 64'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_over_start_busy", 201, 64'(busy), 64'd0);
        @(negedge clk);
        chk("flush_over_start_valid", 201, 64'(valid), 64'd0);

        // Asynchronous reset mid-CALC clears outputs immediately.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 64'd1000; b = 64'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_busy_before", 300, 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 300, 64'(busy), 64'd0);
        chk("rst_mid_valid", 300, 64'(valid), 64'd0);
        chk("rst_mid_result", 300, result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        chk("rst_mid_no_valid", 300, 64'(seen), 64'd0);

        v.op = 2'b00; v.wd = 1'b0; v.a = 64'hFFFF_FFFF_FFFF_FFF9; v.b = 64'd2;
        v.exp = 64'hFFFF_FFFF_FFFF_FFFD; v.lat = LN;
        run_op(v, 301, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 400, 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV64 M extension.
- Sits in EX, directly upstream of the writeback result-select mux; its `result` is one data input of that mux.
- Accepts one operation per `start` pulse and computes quotient or remainder over multiple cycles.
- Signals completion with a one-cycle `valid` pulse, then holds `result` stable until the next accepted start.

Parameters:
- DATA_WIDTH, 64, operand/result width; also the number of iterations for a full-width op.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- word  input  1  32-bit W-variant select; present only with DIV_WORD_OP_EN.
- flush  input  1  pipeline kill; aborts any operation.
- a  input  DATA_WIDTH  dividend.
- b  input  DATA_WIDTH  divisor.
- busy  output  1  high while not IDLE.
- valid  output  1  one-cycle completion pulse.
- result  output  DATA_WIDTH  quotient or remainder; held after valid.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, valid=0, result=0.
  - Counter and internal registers are cleared.
  - Reset asserted mid-operation discards the operation; no valid is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at a rising edge latches a, b, op.
  - Signed ops latch magnitudes plus a quotient sign (sign(a) xor sign(b)) and a remainder sign (sign(a)).
  - Special cases go directly to DONE with the result precomputed:
    - b==0: quotient = all ones; remainder = a.
    - Signed overflow (a = most-negative, b = -1): quotient = a; remainder = 0.
  - All other cases go to CALC with counter=0.
- CALC:
  - Each cycle shifts the {rem, quot} register pair left by 1.
  - Trial-subtracts the divisor from rem; if the subtraction is non-negative, keeps the difference and sets quotient bit 0.
  - Counter increments each cycle; after N iterations, goes to FIX.
  - N = DATA_WIDTH, or 32 for word ops.
- FIX:
  - Applies two's-complement negation per the latched signs (signed ops only).
  - Selects quotient or remainder per op.
  - Word ops: sign-extends bit 31 of the selected value to DATA_WIDTH (DIVUW/REMUW included, per RV64 spec).
  - Loads result; goes to DONE.
- DONE: valid=1 for exactly one cycle, then IDLE. result is unchanged until the next accepted start.
- Latency (start edge to valid high):
  - Normal full-width op: DATA_WIDTH+2 cycles.
  - Normal word op: 34 cycles.
  - Special case: 1 cycle.
- start while busy=1 is ignored; there is no queueing.
- flush=1 at any edge:
  - State goes to IDLE, busy=0 next cycle, valid is suppressed.
  - result is not modified.
  - flush has priority over start in the same cycle.
- busy is registered. It goes high the cycle after the accepted start and low in the cycle valid is high.
- Arithmetic uses DATA_WIDTH+1-bit subtraction for the trial step. No combinational path runs from inputs to outputs.

Optional Feature:
- Macro: DIV_WORD_OP_EN.
- Defined:
  - `word` port exists.
  - word=1 uses a[31:0] and b[31:0], with sign, zero and overflow checks done at 32 bits (overflow: a[31:0]=0x8000_0000, b[31:0]=0xFFFF_FFFF).
  - 32 iterations; result is sign-extended from bit 31.
- Undefined:
  - No `word` port.
  - All ops are full width; the word datapath and its muxing are not synthesized.

Test Plan:
- DIVU, a=100, b=7 → busy high from the cycle after start; valid at cycle 66; result=14. Then REMU on the same operands → result=2.
- REM, a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 → result=0xFFFF_FFFF_FFFF_FFFF (-1). DIV on the same operands → 0xFFFF_FFFF_FFFF_FFFD (-3).
- DIV, b=0, a=5 → valid 1 cycle after start, result=0xFFFF_FFFF_FFFF_FFFF. REM with the same operands → result=5.
- DIV, a=0x8000_0000_0000_0000, b=-1 → valid after 1 cycle, result=0x8000_0000_0000_0000. REM with the same operands → 0.
- DIVU started, flush at cycle 10 → busy=0 at cycle 11, no valid pulse, result keeps its prior value. start pulsed while busy → ignored. rst_n low mid-CALC → outputs 0 immediately.
- With DIV_WORD_OP_EN: DIVW, a=0x0000_0001_FFFF_FFF8, b=2 → valid at cycle 34, result=0xFFFF_FFFF_FFFF_FFFC.
